// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM-side AFS responder.
package dram_pkg;

    localparam int DRAM_ADDR_W = 17;
    localparam int DRAM_DATA_W = 64;
    localparam int DRAM_CNT_W  = 16;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_WR_RESP = 3'd5
    } dram_state_t;

    // Word-aligned and inside [base, base + 8*depth); evaluated in 32 bits so the top end cannot wrap.
    function automatic logic dram_addr_valid(
        input logic [DRAM_ADDR_W-1:0] addr,
        input logic [DRAM_ADDR_W-1:0] base,
        input int unsigned            depth
    );
        logic [31:0] a_s;
        logic [31:0] lo_s;
        logic [31:0] hi_s;
        a_s  = {15'd0, addr};
        lo_s = {15'd0, base};
        hi_s = lo_s + (32'(depth) << 3);
        return (addr[2:0] == 3'd0) && (a_s >= lo_s) && (a_s < hi_s);
    endfunction

endpackage

// File: rtl/dram_lat_ctr.sv
// Loadable latency down-counter; with DRAM_RAND_LAT_EN defined an LFSR adds 0..7 extra cycles per load.
module dram_lat_ctr
    import dram_pkg::*;
#(
    parameter int CNT_W = DRAM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] extra_s;

`ifdef DRAM_RAND_LAT_EN
    logic [15:0] lfsr_r;
    logic        lfsr_fb_s;

    assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    assign extra_s   = CNT_W'(lfsr_r[2:0]);

    // Free-running LFSR, advanced every cycle regardless of FSM activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
        end
    end
`else
    assign extra_s = {CNT_W{1'b0}};
`endif

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val + extra_s;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/dram_axi_responder.sv
// DRAM end of the AFS bus: AXI-lite style AR/R and AW/W/B served from a 64-bit word memory.
// Optional build macro: DRAM_RAND_LAT_EN adds pseudo-random extra wait cycles (see dram_lat_ctr).
module dram_axi_responder
    import dram_pkg::*;
#(
    parameter logic [DRAM_ADDR_W-1:0] BASE_ADDR = 17'h10000,
    parameter int                     DEPTH     = 256,
    parameter int                     RD_LAT    = 4,
    parameter int                     WR_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   AR_VALID,
    input  logic [DRAM_ADDR_W-1:0] AR_ADDR,
    output logic                   AR_READY,
    output logic                   R_VALID,
    output logic [DRAM_DATA_W-1:0] R_DATA,
    output logic [1:0]             R_RESP,
    input  logic                   R_READY,
    input  logic                   AW_VALID,
    input  logic [DRAM_ADDR_W-1:0] AW_ADDR,
    output logic                   AW_READY,
    input  logic                   W_VALID,
    input  logic [DRAM_DATA_W-1:0] W_DATA,
    output logic                   W_READY,
    output logic                   B_VALID,
    output logic [1:0]             B_RESP,
    input  logic                   B_READY
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DRAM_CNT_W-1:0] RD_LOAD = DRAM_CNT_W'(RD_LAT - 1);
    localparam logic [DRAM_CNT_W-1:0] WR_LOAD = DRAM_CNT_W'(WR_LAT - 1);

    dram_state_t            state_r;
    logic [DRAM_ADDR_W-1:0] addr_r;
    logic [DRAM_DATA_W-1:0] mem [DEPTH];

    logic                   addr_ok_s;
    logic [DRAM_ADDR_W-1:0] offset_s;
    logic [IDX_W-1:0]       idx_s;
    logic                   ar_hs_s;
    logic                   aw_hs_s;
    logic                   w_hs_s;
    logic                   r_hs_s;
    logic                   b_hs_s;
    logic                   lat_load_s;
    logic [DRAM_CNT_W-1:0]  lat_val_s;
    logic                   lat_done_s;

    assign AR_READY = (state_r == ST_IDLE);
    assign AW_READY = (state_r == ST_IDLE) && !AR_VALID;

    assign ar_hs_s = AR_VALID && AR_READY;
    assign aw_hs_s = AW_VALID && AW_READY;
    assign w_hs_s  = W_VALID && W_READY;
    assign r_hs_s  = R_VALID && R_READY;
    assign b_hs_s  = B_VALID && B_READY;

    assign addr_ok_s = dram_addr_valid(addr_r, BASE_ADDR, DEPTH);
    assign offset_s  = addr_r - BASE_ADDR;
    assign idx_s     = IDX_W'(offset_s >> 3);

    // Select which wait the latency counter is armed for on the entering handshake.
    always_comb begin
        lat_load_s = 1'b0;
        lat_val_s  = RD_LOAD;
        if (ar_hs_s) begin
            lat_load_s = 1'b1;
            lat_val_s  = RD_LOAD;
        end else if (w_hs_s) begin
            lat_load_s = 1'b1;
            lat_val_s  = WR_LOAD;
        end else begin
            lat_load_s = 1'b0;
            lat_val_s  = RD_LOAD;
        end
    end

    dram_lat_ctr #(
        .CNT_W (DRAM_CNT_W)
    ) u_lat_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load_s),
        .load_val (lat_val_s),
        .done     (lat_done_s)
    );

    // Memory write on the W handshake; a reset on the same edge aborts it.
    always_ff @(posedge clk) begin
        if (!rst && w_hs_s && addr_ok_s) begin
            mem[idx_s] <= W_DATA;
        end
    end

    // Transaction FSM and registered response channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= {DRAM_ADDR_W{1'b0}};
            R_VALID <= 1'b0;
            R_DATA  <= {DRAM_DATA_W{1'b0}};
            R_RESP  <= RESP_OKAY;
            W_READY <= 1'b0;
            B_VALID <= 1'b0;
            B_RESP  <= RESP_OKAY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ar_hs_s) begin
                        addr_r  <= AR_ADDR;
                        state_r <= ST_RD_WAIT;
                    end else if (aw_hs_s) begin
                        addr_r  <= AW_ADDR;
                        W_READY <= 1'b1;
                        state_r <= ST_WR_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_done_s) begin
                        R_VALID <= 1'b1;
                        state_r <= ST_RD_RESP;
                        if (addr_ok_s) begin
                            R_DATA <= mem[idx_s];
                            R_RESP <= RESP_OKAY;
                        end else begin
                            R_DATA <= {DRAM_DATA_W{1'b0}};
                            R_RESP <= RESP_SLVERR;
                        end
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_RD_RESP: begin
                    if (r_hs_s) begin
                        R_VALID <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RD_RESP;
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs_s) begin
                        W_READY <= 1'b0;
                        state_r <= ST_WR_WAIT;
                    end else begin
                        state_r <= ST_WR_DATA;
                    end
                end
                ST_WR_WAIT: begin
                    if (lat_done_s) begin
                        B_VALID <= 1'b1;
                        B_RESP  <= addr_ok_s ? RESP_OKAY : RESP_SLVERR;
                        state_r <= ST_WR_RESP;
                    end else begin
                        state_r <= ST_WR_WAIT;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs_s) begin
                        B_VALID <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WR_RESP;
                    end
                end
                default: begin
                    R_VALID <= 1'b0;
                    W_READY <= 1'b0;
                    B_VALID <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_axi_responder.sv
// Directed plus randomized bench for dram_axi_responder against a word-level memory model.
module tb_dram_axi_responder;

    localparam int BASE   = 32'h10000;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        AR_VALID = 1'b0;
    logic [16:0] AR_ADDR = 17'd0;
    logic        AR_READY;
    logic        R_VALID;
    logic [63:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        R_READY = 1'b0;
    logic        AW_VALID = 1'b0;
    logic [16:0] AW_ADDR = 17'd0;
    logic        AW_READY;
    logic        W_VALID = 1'b0;
    logic [63:0] W_DATA = 64'd0;
    logic        W_READY;
    logic        B_VALID;
    logic [1:0]  B_RESP;
    logic        B_READY = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    logic [63:0] mdl [int];

    dram_axi_responder dut (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [16:0] a);
        int ai;
        ai = int'(a);
        return (ai % 8 == 0) && (ai >= BASE) && (ai < BASE + 8 * DEPTH);
    endfunction

    function automatic int widx(input logic [16:0] a);
        return (int'(a) - BASE) / 8;
    endfunction

    task automatic check_lat(input string tag, input int n, input int lat);
`ifdef DRAM_RAND_LAT_EN
        check(tag, 64'((n >= lat) && (n <= lat + 7)), 64'd1);
`else
        check(tag, 64'(n), 64'(lat));
`endif
    endtask

    task automatic do_write(input logic [16:0] a, input logic [63:0] d, input int bp);
        int n;
        bit ok;
        ok = addr_ok(a);
        AW_VALID = 1'b1;
        AW_ADDR  = a;
        #1;
        n = 0;
        while (!AW_READY && n < 40) begin
            step();
            n++;
        end
        check("aw_ready", 64'(AW_READY), 64'd1);
        step();
        AW_VALID = 1'b0;
        check("w_ready_up", 64'(W_READY), 64'd1);
        W_VALID = 1'b1;
        W_DATA  = d;
        step();
        W_VALID = 1'b0;
        check("w_ready_drop", 64'(W_READY), 64'd0);
        n = 0;
        while (!B_VALID && n < 40) begin
            step();
            n++;
        end
        check_lat("wr_lat", n, WR_LAT);
        check("b_resp", 64'(B_RESP), ok ? 64'd0 : 64'd2);
        for (int i = 0; i < bp; i++) begin
            step();
            check("b_hold", 64'(B_VALID), 64'd1);
            check("b_resp_hold", 64'(B_RESP), ok ? 64'd0 : 64'd2);
        end
        B_READY = 1'b1;
        step();
        B_READY = 1'b0;
        check("b_drop", 64'(B_VALID), 64'd0);
        if (ok) mdl[widx(a)] = d;
    endtask

    task automatic do_read(input logic [16:0] a, input int bp);
        int n;
        bit ok;
        logic [63:0] exp_d;
        ok    = addr_ok(a);
        exp_d = ok ? mdl[widx(a)] : 64'd0;
        AR_VALID = 1'b1;
        AR_ADDR  = a;
        #1;
        n = 0;
        while (!AR_READY && n < 40) begin
            step();
            n++;
        end
        check("ar_ready", 64'(AR_READY), 64'd1);
        step();
        AR_VALID = 1'b0;
        n = 0;
        while (!R_VALID && n < 40) begin
            step();
            n++;
        end
        check_lat("rd_lat", n, RD_LAT);
        check("r_data", R_DATA, exp_d);
        check("r_resp", 64'(R_RESP), ok ? 64'd0 : 64'd2);
        for (int i = 0; i < bp; i++) begin
            step();
            check("r_valid_hold", 64'(R_VALID), 64'd1);
            check("r_data_hold", R_DATA, exp_d);
            check("r_resp_hold", 64'(R_RESP), ok ? 64'd0 : 64'd2);
        end
        R_READY = 1'b1;
        step();
        R_READY = 1'b0;
        check("r_drop", 64'(R_VALID), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_r_valid"}, 64'(R_VALID), 64'd0);
        check({tag, "_w_ready"}, 64'(W_READY), 64'd0);
        check({tag, "_b_valid"}, 64'(B_VALID), 64'd0);
        check({tag, "_r_data"}, R_DATA, 64'd0);
        check({tag, "_r_resp"}, 64'(R_RESP), 64'd0);
        check({tag, "_b_resp"}, 64'(B_RESP), 64'd0);
        check({tag, "_ar_ready"}, 64'(AR_READY), 64'd1);
    endtask

    initial begin
        logic [16:0] a;
        logic [63:0] d;
        bit          is_rd;

        rst = 1'b1;
        repeat (3) step();
        check_reset_outputs("rst0");
        check("rst0_aw_ready", 64'(AW_READY), 64'd1);
        rst = 1'b0;
        step();

        // Basic write then read, then backpressure on both response channels.
        do_write(17'h10008, 64'h0123_4567_89AB_CDEF, 0);
        do_read(17'h10008, 0);
        do_read(17'h10008, 5);
        do_write(17'h10020, 64'hDEAD_BEEF_0BAD_F00D, 3);
        do_read(17'h10020, 1);

        // Boundary words.
        do_write(17'h10000, 64'hA5A5_0000_1111_5A5A, 0);
        do_write(17'h107F8, 64'h7777_8888_9999_AAAA, 0);
        do_read(17'h10000, 0);
        do_read(17'h107F8, 0);

        // Same-cycle AR and AW: read wins, AW follows.
        AR_VALID = 1'b1;
        AR_ADDR  = 17'h10000;
        AW_VALID = 1'b1;
        AW_ADDR  = 17'h10010;
        #1;
        check("tie_ar_ready", 64'(AR_READY), 64'd1);
        check("tie_aw_ready", 64'(AW_READY), 64'd0);
        do_read(17'h10000, 0);
        do_write(17'h10010, 64'h0F0F_F0F0_1234_4321, 0);
        do_read(17'h10010, 0);

        // Error responses; the last valid word must be unaffected.
        do_read(17'h10004, 0);
        do_write(17'h10800, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_read(17'h107F8, 0);

        // Reset while waiting for W data: transaction aborted, memory untouched.
        AW_VALID = 1'b1;
        AW_ADDR  = 17'h10008;
        step();
        AW_VALID = 1'b0;
        check("rstw_w_ready", 64'(W_READY), 64'd1);
        W_DATA = 64'h1111_2222_3333_4444;
        rst = 1'b1;
        step();
        check_reset_outputs("rstw");
        rst = 1'b0;
        do_read(17'h10008, 0);

        // Randomized mix of valid and invalid accesses.
        for (int it = 0; it < 24; it++) begin
            is_rd = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                a = 17'($urandom_range(0, 32'h1FFFF));
            end else begin
                a = 17'(BASE + 8 * $urandom_range(0, DEPTH - 1));
            end
            d = {$urandom, $urandom};
            if (is_rd && addr_ok(a) && !mdl.exists(widx(a))) is_rd = 1'b0;
            if (is_rd) do_read(a, $urandom_range(0, 3));
            else       do_write(a, d, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
